// File: rtl/lsu_axil_sram_slave.sv
// AXI4-Lite SRAM responder behind the load/store unit: independent read and write
// paths, each with a programmable fixed access latency to exercise master-side stalls.
module lsu_axil_sram_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          RD_LAT     = 3,
    parameter int          WR_LAT     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] saxi_araddr,
    input  logic        saxi_arvalid,
    output logic        saxi_arready,
    output logic [31:0] saxi_rdata,
    output logic [1:0]  saxi_rresp,
    output logic        saxi_rvalid,
    input  logic        saxi_rready,
    input  logic [31:0] saxi_awaddr,
    input  logic        saxi_awvalid,
    output logic        saxi_awready,
    input  logic [31:0] saxi_wdata,
    input  logic [3:0]  saxi_wstrb,
    input  logic        saxi_wvalid,
    output logic        saxi_wready,
    output logic [1:0]  saxi_bresp,
    output logic        saxi_bvalid,
    input  logic        saxi_bready
);

    localparam int                WORDS       = 1 << DEPTH_LOG2;
    localparam logic [32:0]       END_ADDR    = {1'b0, BASE_ADDR} + (33'd4 << DEPTH_LOG2);
    localparam int                CNT_W       = 8;
    localparam logic [CNT_W-1:0]  RD_CNT      = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0]  WR_CNT      = CNT_W'(WR_LAT);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

    function automatic logic in_range(input logic [31:0] addr);
        return (addr >= BASE_ADDR) && ({1'b0, addr} < END_ADDR);
    endfunction

    logic [31:0] mem [WORDS];

    // ------------------------------------------------------------------ read path
    r_state_t              r_state, r_state_n;
    logic [CNT_W-1:0]      r_cnt, r_cnt_n;
    logic [31:0]           r_addr;
    logic [31:0]           r_src_addr;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [31:0]           r_mem_word;
    logic                  r_sample;

    assign saxi_arready = (r_state == R_IDLE);
    assign saxi_rvalid  = (r_state == R_RESP);

    // With zero latency the sample happens on the handshake edge, before r_addr is loaded.
    assign r_src_addr = (r_state == R_IDLE) ? saxi_araddr : r_addr;
    assign r_idx      = r_src_addr[DEPTH_LOG2+1:2];
    assign r_mem_word = mem[r_idx];

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        r_state_n = r_state;
        r_cnt_n   = r_cnt;
        r_sample  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (saxi_arvalid) begin
                    if (RD_LAT == 0) begin
                        r_sample  = 1'b1;
                        r_state_n = R_RESP;
                    end else begin
                        r_cnt_n   = RD_CNT;
                        r_state_n = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                r_cnt_n = r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    r_sample  = 1'b1;
                    r_state_n = R_RESP;
                end
            end
            R_RESP: begin
                if (saxi_rready) r_state_n = R_IDLE;
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; this is also what makes a same-edge read see the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= R_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            saxi_rdata <= '0;
            saxi_rresp <= RESP_OKAY;
        end else begin
            r_state <= r_state_n;
            r_cnt   <= r_cnt_n;
            if (saxi_arvalid && saxi_arready) r_addr <= saxi_araddr;
            if (r_sample) begin
                if (in_range(r_src_addr)) begin
                    saxi_rdata <= r_mem_word;
                    saxi_rresp <= RESP_OKAY;
                end else begin
                    saxi_rdata <= '0;
                    saxi_rresp <= RESP_SLVERR;
                end
            end
        end
    end

    // ----------------------------------------------------------------- write path
    w_state_t              w_state, w_state_n;
    logic [CNT_W-1:0]      w_cnt, w_cnt_n;
    logic [31:0]           w_addr;
    logic [31:0]           w_data;
    logic [3:0]            w_strb;
    logic [31:0]           w_src_addr;
    logic [31:0]           w_src_data;
    logic [3:0]            w_src_strb;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_commit;
    logic                  w_hs;

    assign saxi_awready = (w_state == W_IDLE);
    assign saxi_wready  = (w_state == W_IDLE);
    assign saxi_bvalid  = (w_state == W_RESP);

    // Address and data are only ever taken together; a lone channel waits.
    assign w_hs = (w_state == W_IDLE) && saxi_awvalid && saxi_wvalid;

    assign w_src_addr = (w_state == W_IDLE) ? saxi_awaddr : w_addr;
    assign w_src_data = (w_state == W_IDLE) ? saxi_wdata  : w_data;
    assign w_src_strb = (w_state == W_IDLE) ? saxi_wstrb  : w_strb;
    assign w_idx      = w_src_addr[DEPTH_LOG2+1:2];

    always_comb begin
        w_state_n = w_state;
        w_cnt_n   = w_cnt;
        w_commit  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if (w_hs) begin
                    if (WR_LAT == 0) begin
                        w_commit  = 1'b1;
                        w_state_n = W_RESP;
                    end else begin
                        w_cnt_n   = WR_CNT;
                        w_state_n = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                w_cnt_n = w_cnt - CNT_ONE;
                if (w_cnt == CNT_ONE) begin
                    w_commit  = 1'b1;
                    w_state_n = W_RESP;
                end
            end
            W_RESP: begin
                if (saxi_bready) w_state_n = W_IDLE;
            end
            default: w_state_n = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state    <= W_IDLE;
            w_cnt      <= '0;
            w_addr     <= '0;
            w_data     <= '0;
            w_strb     <= '0;
            saxi_bresp <= RESP_OKAY;
        end else begin
            w_state <= w_state_n;
            w_cnt   <= w_cnt_n;
            if (w_hs) begin
                w_addr <= saxi_awaddr;
                w_data <= saxi_wdata;
                w_strb <= saxi_wstrb;
            end
            if (w_commit) saxi_bresp <= in_range(w_src_addr) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // NOTE: the array has no reset; clearing it would turn the RAM into a register file.
    always_ff @(posedge clk) begin
        if (w_commit && in_range(w_src_addr)) begin
            for (int i = 0; i < 4; i++) begin
                if (w_src_strb[i]) mem[w_idx][8*i +: 8] <= w_src_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_lsu_axil_sram_slave.sv
// Directed bench for lsu_axil_sram_slave: latency, backpressure, strobes, decode errors,
// async reset and same-edge read/write collision.
module tb_lsu_axil_sram_slave;

    localparam int MAIN_RD_CYC = 4;   // RD_LAT 3 + handshake cycle
    localparam int MAIN_WR_CYC = 3;   // WR_LAT 2 + handshake cycle
    localparam int COL_CYC     = 3;   // RD_LAT = WR_LAT = 2 on the collision instance

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic [31:0] saxi_araddr = '0;
    logic        saxi_arvalid = 1'b0;
    logic        saxi_arready;
    logic [31:0] saxi_rdata;
    logic [1:0]  saxi_rresp;
    logic        saxi_rvalid;
    logic        saxi_rready = 1'b0;
    logic [31:0] saxi_awaddr = '0;
    logic        saxi_awvalid = 1'b0;
    logic        saxi_awready;
    logic [31:0] saxi_wdata = '0;
    logic [3:0]  saxi_wstrb = '0;
    logic        saxi_wvalid = 1'b0;
    logic        saxi_wready;
    logic [1:0]  saxi_bresp;
    logic        saxi_bvalid;
    logic        saxi_bready = 1'b0;

    logic [31:0] c_araddr = '0;
    logic        c_arvalid = 1'b0;
    logic        c_arready;
    logic [31:0] c_rdata;
    logic [1:0]  c_rresp;
    logic        c_rvalid;
    logic        c_rready = 1'b0;
    logic [31:0] c_awaddr = '0;
    logic        c_awvalid = 1'b0;
    logic        c_awready;
    logic [31:0] c_wdata = '0;
    logic [3:0]  c_wstrb = '0;
    logic        c_wvalid = 1'b0;
    logic        c_wready;
    logic [1:0]  c_bresp;
    logic        c_bvalid;
    logic        c_bready = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_axil_sram_slave u_dut (
        .clk          (clk),
        .rst          (rst),
        .saxi_araddr  (saxi_araddr),
        .saxi_arvalid (saxi_arvalid),
        .saxi_arready (saxi_arready),
        .saxi_rdata   (saxi_rdata),
        .saxi_rresp   (saxi_rresp),
        .saxi_rvalid  (saxi_rvalid),
        .saxi_rready  (saxi_rready),
        .saxi_awaddr  (saxi_awaddr),
        .saxi_awvalid (saxi_awvalid),
        .saxi_awready (saxi_awready),
        .saxi_wdata   (saxi_wdata),
        .saxi_wstrb   (saxi_wstrb),
        .saxi_wvalid  (saxi_wvalid),
        .saxi_wready  (saxi_wready),
        .saxi_bresp   (saxi_bresp),
        .saxi_bvalid  (saxi_bvalid),
        .saxi_bready  (saxi_bready)
    );

    lsu_axil_sram_slave #(.RD_LAT(2), .WR_LAT(2)) u_dut_col (
        .clk          (clk),
        .rst          (rst),
        .saxi_araddr  (c_araddr),
        .saxi_arvalid (c_arvalid),
        .saxi_arready (c_arready),
        .saxi_rdata   (c_rdata),
        .saxi_rresp   (c_rresp),
        .saxi_rvalid  (c_rvalid),
        .saxi_rready  (c_rready),
        .saxi_awaddr  (c_awaddr),
        .saxi_awvalid (c_awvalid),
        .saxi_awready (c_awready),
        .saxi_wdata   (c_wdata),
        .saxi_wstrb   (c_wstrb),
        .saxi_wvalid  (c_wvalid),
        .saxi_wready  (c_wready),
        .saxi_bresp   (c_bresp),
        .saxi_bvalid  (c_bvalid),
        .saxi_bready  (c_bready)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Read on the main instance; bp = cycles rready is held low once rvalid is up.
    task automatic do_read(input string tag, input logic [31:0] addr, input int bp,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int n;
        int lat;
        @(negedge clk);
        saxi_araddr  = addr;
        saxi_arvalid = 1'b1;
        saxi_rready  = 1'b0;
        n = 0;
        while (!saxi_arready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ar_accept"}, 32'(saxi_arready), 32'd1);
        @(posedge clk);
        #1 saxi_arvalid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!saxi_rvalid && lat < 50);
        check({tag, "_rvalid"}, 32'(saxi_rvalid), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(MAIN_RD_CYC));
        check({tag, "_rdata"}, saxi_rdata, exp_data);
        check({tag, "_rresp"}, 32'(saxi_rresp), 32'(exp_resp));
        if (bp > 0) begin
            saxi_arvalid = 1'b1;
            saxi_araddr  = addr ^ 32'h4;
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                check({tag, "_bp_rvalid"}, 32'(saxi_rvalid), 32'd1);
                check({tag, "_bp_rdata"}, saxi_rdata, exp_data);
                check({tag, "_bp_arready"}, 32'(saxi_arready), 32'd0);
            end
            saxi_arvalid = 1'b0;
        end
        saxi_rready = 1'b1;
        @(negedge clk);
        saxi_rready = 1'b0;
        check({tag, "_done_rvalid"}, 32'(saxi_rvalid), 32'd0);
        check({tag, "_done_arready"}, 32'(saxi_arready), 32'd1);
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp);
        int n;
        int lat;
        @(negedge clk);
        saxi_awaddr  = addr;
        saxi_wdata   = data;
        saxi_wstrb   = strb;
        saxi_awvalid = 1'b1;
        saxi_wvalid  = 1'b1;
        saxi_bready  = 1'b0;
        n = 0;
        while (!(saxi_awready && saxi_wready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_aw_accept"}, 32'(saxi_awready && saxi_wready), 32'd1);
        @(posedge clk);
        #1;
        saxi_awvalid = 1'b0;
        saxi_wvalid  = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!saxi_bvalid && lat < 50);
        check({tag, "_bvalid"}, 32'(saxi_bvalid), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(MAIN_WR_CYC));
        check({tag, "_bresp"}, 32'(saxi_bresp), 32'(exp_resp));
        saxi_bready = 1'b1;
        @(negedge clk);
        saxi_bready = 1'b0;
        check({tag, "_done_bvalid"}, 32'(saxi_bvalid), 32'd0);
        check({tag, "_done_awready"}, 32'(saxi_awready), 32'd1);
    endtask

    // Collision-instance helpers: ready held high, only data and latency are checked.
    task automatic c_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        int lat;
        @(negedge clk);
        c_awaddr  = addr;
        c_wdata   = data;
        c_wstrb   = 4'hF;
        c_awvalid = 1'b1;
        c_wvalid  = 1'b1;
        c_bready  = 1'b1;
        @(posedge clk);
        #1;
        c_awvalid = 1'b0;
        c_wvalid  = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!c_bvalid && lat < 50);
        check({tag, "_lat"}, 32'(lat), 32'(COL_CYC));
        check({tag, "_bresp"}, 32'(c_bresp), 32'd0);
        @(negedge clk);
        c_bready = 1'b0;
    endtask

    task automatic c_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data);
        int lat;
        @(negedge clk);
        c_araddr  = addr;
        c_arvalid = 1'b1;
        c_rready  = 1'b1;
        @(posedge clk);
        #1 c_arvalid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!c_rvalid && lat < 50);
        check({tag, "_lat"}, 32'(lat), 32'(COL_CYC));
        check({tag, "_rdata"}, c_rdata, exp_data);
        @(negedge clk);
        c_rready = 1'b0;
    endtask

    initial begin
        int  n;
        bit  got_r;
        bit  got_b;
        int  r_lat;
        int  b_lat;
        logic [31:0] col_rdata;
        logic [1:0]  col_rresp;
        logic [1:0]  col_bresp;

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("rst0_arready", 32'(saxi_arready), 32'd1);
        check("rst0_awready", 32'(saxi_awready), 32'd1);
        check("rst0_wready",  32'(saxi_wready),  32'd1);
        check("rst0_rvalid",  32'(saxi_rvalid),  32'd0);
        check("rst0_bvalid",  32'(saxi_bvalid),  32'd0);
        check("rst0_rdata",   saxi_rdata,        32'd0);
        check("rst0_rresp",   32'(saxi_rresp),   32'd0);
        check("rst0_bresp",   32'(saxi_bresp),   32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_arready", 32'(saxi_arready), 32'd1);
        check("idle_rvalid",  32'(saxi_rvalid),  32'd0);
        check("idle_bvalid",  32'(saxi_bvalid),  32'd0);

        // Single read latency, then the same word under backpressure.
        do_write("wr_beef", 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00);
        do_read("rd_beef", 32'h8000_0010, 0, 32'hDEAD_BEEF, 2'b00);
        do_read("rd_bp", 32'h8000_0010, 5, 32'hDEAD_BEEF, 2'b00);

        // Strobed writes and an empty strobe.
        do_write("wr_full", 32'h8000_0020, 32'h1122_3344, 4'hF, 2'b00);
        do_write("wr_strb", 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 2'b00);
        do_read("rd_strb", 32'h8000_0020, 0, 32'h11BB_33DD, 2'b00);
        do_write("wr_nostrb", 32'h8000_0020, 32'hFFFF_FFFF, 4'b0000, 2'b00);
        do_read("rd_nostrb", 32'h8000_0020, 0, 32'h11BB_33DD, 2'b00);

        // Out-of-range accesses must not disturb the first or last word.
        do_write("wr_first", 32'h8000_0000, 32'hA5A5_0001, 4'hF, 2'b00);
        do_write("wr_last",  32'h8000_0FFC, 32'h5A5A_0FFC, 4'hF, 2'b00);
        do_write("wr_below", 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 2'b10);
        do_write("wr_above", 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 2'b10);
        do_read("rd_below", 32'h7FFF_FFFC, 0, 32'h0, 2'b10);
        do_read("rd_above", 32'h8000_1000, 0, 32'h0, 2'b10);
        do_read("rd_first", 32'h8000_0000, 0, 32'hA5A5_0001, 2'b00);
        do_read("rd_last",  32'h8000_0FFC, 0, 32'h5A5A_0FFC, 2'b00);

        // Lone address, then lone data: neither may be accepted.
        @(negedge clk);
        saxi_awaddr  = 32'h8000_0020;
        saxi_wdata   = 32'hFFFF_FFFF;
        saxi_wstrb   = 4'hF;
        saxi_awvalid = 1'b1;
        repeat (6) @(negedge clk);
        check("lone_aw_bvalid", 32'(saxi_bvalid), 32'd0);
        check("lone_aw_awready", 32'(saxi_awready), 32'd1);
        saxi_awvalid = 1'b0;
        saxi_wvalid  = 1'b1;
        repeat (6) @(negedge clk);
        check("lone_w_bvalid", 32'(saxi_bvalid), 32'd0);
        saxi_wvalid = 1'b0;
        do_read("rd_lone", 32'h8000_0020, 0, 32'h11BB_33DD, 2'b00);

        // Read and write in flight together, then reset mid-cycle drops both.
        @(negedge clk);
        saxi_araddr  = 32'h8000_0010;
        saxi_arvalid = 1'b1;
        saxi_awaddr  = 32'h8000_0010;
        saxi_wdata   = 32'hDEAD_BEEF;
        saxi_wstrb   = 4'hF;
        saxi_awvalid = 1'b1;
        saxi_wvalid  = 1'b1;
        saxi_rready  = 1'b0;
        saxi_bready  = 1'b0;
        @(posedge clk);
        #1;
        saxi_arvalid = 1'b0;
        saxi_awvalid = 1'b0;
        saxi_wvalid  = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_rvalid", 32'(saxi_rvalid), 32'd1);
        check("pre_rst_bvalid", 32'(saxi_bvalid), 32'd1);
        check("pre_rst_rdata",  saxi_rdata,       32'hDEAD_BEEF);
        #2 rst = 1'b1;
        #1;
        check("rst_rvalid",  32'(saxi_rvalid),  32'd0);
        check("rst_bvalid",  32'(saxi_bvalid),  32'd0);
        check("rst_rdata",   saxi_rdata,        32'd0);
        check("rst_arready", 32'(saxi_arready), 32'd1);
        check("rst_awready", 32'(saxi_awready), 32'd1);
        check("rst_wready",  32'(saxi_wready),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_rvalid", 32'(saxi_rvalid), 32'd0);
        check("post_rst_bvalid", 32'(saxi_bvalid), 32'd0);

        // Same-cycle AR and AW/W to one word: the read sees the old contents.
        c_write("col_init", 32'h8000_0040, 32'h0000_0000);
        @(negedge clk);
        c_araddr  = 32'h8000_0040;
        c_awaddr  = 32'h8000_0040;
        c_wdata   = 32'hFFFF_FFFF;
        c_wstrb   = 4'hF;
        c_arvalid = 1'b1;
        c_awvalid = 1'b1;
        c_wvalid  = 1'b1;
        c_rready  = 1'b1;
        c_bready  = 1'b1;
        @(posedge clk);
        #1;
        c_arvalid = 1'b0;
        c_awvalid = 1'b0;
        c_wvalid  = 1'b0;
        got_r = 1'b0;
        got_b = 1'b0;
        r_lat = 0;
        b_lat = 0;
        col_rdata = '0;
        col_rresp = '0;
        col_bresp = '0;
        n = 0;
        while (!(got_r && got_b) && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("col_arready_busy", 32'(c_arready), 32'd0);
                check("col_awready_busy", 32'(c_awready), 32'd0);
            end
            if (c_rvalid && !got_r) begin
                got_r     = 1'b1;
                r_lat     = n;
                col_rdata = c_rdata;
                col_rresp = c_rresp;
            end
            if (c_bvalid && !got_b) begin
                got_b     = 1'b1;
                b_lat     = n;
                col_bresp = c_bresp;
            end
        end
        check("col_r_seen", 32'(got_r), 32'd1);
        check("col_b_seen", 32'(got_b), 32'd1);
        check("col_r_lat", 32'(r_lat), 32'(COL_CYC));
        check("col_b_lat", 32'(b_lat), 32'(COL_CYC));
        check("col_rdata", col_rdata, 32'h0000_0000);
        check("col_rresp", 32'(col_rresp), 32'd0);
        check("col_bresp", 32'(col_bresp), 32'd0);
        @(negedge clk);
        c_rready = 1'b0;
        c_bready = 1'b0;
        c_read("col_after", 32'h8000_0040, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
